// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int         FRAME_TICKS_DEFAULT = 11;
  localparam logic [3:0] HDR_NIBBLE_DEFAULT  = 4'hA;

  typedef enum logic [2:0] {
    GUARD,
    IDLE,
    HDR_GO,
    PAY_GO,
    WAIT
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin pick: first set request strictly after last_grant, wrapping.
module rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    winner,
  output logic             found
);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(last_grant) + k) % N_REQ]) begin
        winner = GW'((int'(last_grant) + k) % N_REQ);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N byte requesters onto one UART serializer, with optional tag header
// and a post-reset guard that lets an in-flight frame drain.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int         N_REQ       = 4,
  parameter int         FRAME_TICKS = FRAME_TICKS_DEFAULT,
  parameter logic [3:0] HDR_NIBBLE  = HDR_NIBBLE_DEFAULT
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       tag_en,
  input  logic                       RTS,
  input  logic                       BaudTick,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(FRAME_TICKS + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(FRAME_TICKS - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      last_q, last_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [7:0]         hold_q, hold_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic               hdr_q, hdr_d;
  logic               busy_q, busy_d;

  logic [GW-1:0]      rr_winner;
  logic               rr_found;
  logic [7:0]         sel_data;
  logic [3:0]         gid_ext;

  rr_select #(.N_REQ(N_REQ), .GW(GW)) u_rr_select (
    .req        (req_valid),
    .last_grant (last_q),
    .winner     (rr_winner),
    .found      (rr_found)
  );

  assign sel_data = req_data[8*int'(rr_winner) +: 8];
  assign gid_ext  = 4'(rr_winner);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    hold_d      = hold_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    req_ready_d = '0;
    hdr_d       = hdr_q;

    case (state_q)
      GUARD: begin
        if (BaudTick) begin
          if (cnt_q == LAST_TICK) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      IDLE: begin
        if (RTS && rr_found) begin
          grant_d                = rr_winner;
          last_d                 = rr_winner;
          hold_d                 = sel_data;
          req_ready_d[rr_winner] = 1'b1;
          tx_start_d             = 1'b1;
          cnt_d                  = '0;
          if (tag_en) begin
            state_d   = HDR_GO;
            tx_data_d = {HDR_NIBBLE, gid_ext};
          end else begin
            state_d   = PAY_GO;
            tx_data_d = sel_data;
          end
        end
      end

      HDR_GO, PAY_GO: begin
        // tx_start is registered, so a stalled GO state raises it one cycle after RTS returns
        if (tx_start_q) begin
          state_d = WAIT;
          cnt_d   = '0;
          hdr_d   = (state_q == HDR_GO);
        end else if (RTS) begin
          tx_start_d = 1'b1;
        end
      end

      WAIT: begin
        if (BaudTick) begin
          if (cnt_q == LAST_TICK) begin
            cnt_d = '0;
            if (hdr_q) begin
              state_d    = PAY_GO;
              tx_data_d  = hold_q;
              tx_start_d = RTS;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= GUARD;
      cnt_q       <= '0;
      last_q      <= GW'(N_REQ - 1);
      grant_q     <= '0;
      hold_q      <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      hdr_q       <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      hold_q      <= hold_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
      hdr_q       <= hdr_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 11-tick frames).
module tb_uart_tx_arbiter;

  logic        sys_clk;
  logic        sys_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tag_en;
  logic        RTS;
  logic        BaudTick;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [1:0]  grant_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_seen = 0;
  int start_seen = 0;

  uart_tx_arbiter dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tag_en    (tag_en),
    .RTS       (RTS),
    .BaudTick  (BaudTick),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
    if (|req_ready) rdy_seen++;
    if (tx_start) start_seen++;
  endtask

  task automatic tick_edge();
    BaudTick = 1'b1;
    step();
    BaudTick = 1'b0;
  endtask

  function automatic logic [7:0] byte_of(input int i);
    logic [31:0] d;
    d = req_data;
    return d[8*i +: 8];
  endfunction

  // Called on a cycle where tx_start is high; ends just after the 11th counted tick.
  task automatic frame_gap(input string tag, input logic coinc);
    BaudTick = coinc;
    step();
    BaudTick = 1'b0;
    check({tag, "_rdy_1cyc"}, req_ready, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      tick_edge();
      step();
    end
    check({tag, "_busy_after10"}, busy, 1'b1);
    check({tag, "_nostart_after10"}, tx_start, 1'b0);
    tick_edge();
  endtask

  task automatic expect_grant(input string tag, input int idx, input logic [7:0] data);
    check({tag, "_ready"}, req_ready, 32'(4'b0001 << idx));
    check({tag, "_start"}, tx_start, 1'b1);
    check({tag, "_grant"}, grant_id, idx);
    check({tag, "_data"}, tx_data, data);
  endtask

  initial begin
    int r0, s0;
    logic bad;
    logic seen;

    sys_rst   = 1'b1;
    req_valid = 4'b0001;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    tag_en    = 1'b0;
    RTS       = 1'b1;
    BaudTick  = 1'b0;
    @(negedge sys_clk);
    step();
    step();

    // Reset state
    check("rst_busy", busy, 1'b1);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_start", tx_start, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_grant", grant_id, 2'd0);

    // Post-reset guard
    sys_rst = 1'b0;
    r0 = rdy_seen;
    s0 = start_seen;
    for (int i = 0; i < 10; i++) begin
      tick_edge();
      step();
    end
    tick_edge();
    check("guard_no_ready", rdy_seen - r0, 0);
    check("guard_no_start", start_seen - s0, 0);
    step();
    expect_grant("guard_first", 0, 8'h11);

    // Round robin 0,1,2,3,0
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      frame_gap($sformatf("rr%0d", k), 1'b0);
      check($sformatf("rr%0d_idle", k), busy, 1'b0);
      step();
      expect_grant($sformatf("rr%0d", k), (k + 1) % 4, byte_of((k + 1) % 4));
    end
    req_valid = 4'b0000;
    frame_gap("rr_end", 1'b0);
    check("rr_end_idle", busy, 1'b0);

    // Tagging: requester 2 sends 8'h5C
    req_data[23:16] = 8'h5C;
    req_valid = 4'b0100;
    tag_en    = 1'b1;
    r0 = rdy_seen;
    step();
    expect_grant("tag_hdr", 2, 8'hA2);
    req_valid = 4'b0000;
    tag_en    = 1'b0;
    frame_gap("tag_hdr", 1'b0);
    check("tag_pay_start", tx_start, 1'b1);
    check("tag_pay_data", tx_data, 8'h5C);
    check("tag_pay_ready", req_ready, 4'b0000);
    frame_gap("tag_pay", 1'b0);
    check("tag_single_ready", rdy_seen - r0, 1);
    check("tag_end_idle", busy, 1'b0);

    // Coincident tick on tx_start is not counted (last grant 2 -> requester 0)
    req_valid = 4'b0001;
    step();
    expect_grant("coinc", 0, 8'h11);
    req_valid = 4'b0000;
    frame_gap("coinc", 1'b1);
    check("coinc_idle_after11", busy, 1'b0);

    // RTS stall between header and payload (last grant 0 -> requester 3)
    req_valid = 4'b1000;
    tag_en    = 1'b1;
    r0 = rdy_seen;
    step();
    expect_grant("stall_hdr", 3, 8'hA3);
    req_valid = 4'b0000;
    tag_en    = 1'b0;
    step();
    RTS = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_edge();
      step();
    end
    tick_edge();
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tx_start !== 1'b0 || tx_data !== 8'h44 || busy !== 1'b1) bad = 1'b1;
      step();
    end
    check("stall_held", bad, 1'b0);
    RTS = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step();
      if (tx_start) seen = 1'b1;
    end
    check("stall_resume_start", seen, 1'b1);
    check("stall_resume_data", tx_data, 8'h44);
    frame_gap("stall_pay", 1'b0);
    check("stall_single_ready", rdy_seen - r0, 1);
    check("stall_end_idle", busy, 1'b0);

    // Reset mid-WAIT (last grant 3 -> requester 0)
    req_valid = 4'b0001;
    step();
    expect_grant("mid", 0, 8'h11);
    step();
    for (int i = 0; i < 5; i++) begin
      tick_edge();
      step();
    end
    req_valid = 4'b0011;
    sys_rst   = 1'b1;
    step();
    sys_rst   = 1'b0;
    check("mid_rst_busy", busy, 1'b1);
    check("mid_rst_ready", req_ready, 4'b0000);
    check("mid_rst_start", tx_start, 1'b0);
    check("mid_rst_data", tx_data, 8'h00);
    check("mid_rst_grant", grant_id, 2'd0);
    r0 = rdy_seen;
    s0 = start_seen;
    for (int i = 0; i < 10; i++) begin
      tick_edge();
      step();
    end
    tick_edge();
    check("mid_guard_no_ready", rdy_seen - r0, 0);
    check("mid_guard_no_start", start_seen - s0, 0);
    step();
    expect_grant("mid_regrant", 0, 8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
